// File: rtl/dcp_tx_fmt.sv
// rtl/dcp_tx_fmt.sv - debug print transmitter: raw char or 8 hex digits, sent as 8N1 UART.
// Optional macro TX_HEX_SPACE_EN appends a space after each hex word.
module dcp_tx_fmt #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_tx,
  input  logic        type_tx,
  input  logic [31:0] din,
  output logic        ack_tx,
  output logic        busy,
  output logic        txd
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
`ifdef TX_HEX_SPACE_EN
  localparam logic [3:0] HEX_CHARS = 4'd9;
`else
  localparam logic [3:0] HEX_CHARS = 4'd8;
`endif

  typedef enum logic [2:0] {IDLE, LOAD, START, BITS, STOP, ACK, REARM} state_t;

  state_t        state, state_d;
  logic [DW-1:0] div_cnt, div_cnt_d;
  logic [2:0]    bit_cnt, bit_cnt_d;
  logic [3:0]    char_cnt, char_cnt_d;
  logic [31:0]   word, word_d;
  logic          typ, typ_d;
  logic [7:0]    tx_byte, tx_byte_d;
  logic          ack_d, busy_d, txd_d;
  logic [3:0]    n_chars, char_nxt;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    hex_ascii = (n < 4'd10) ? (8'h30 + {4'd0, n}) : (8'h41 + {4'd0, n} - 8'd10);
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      char_cnt <= '0;
      word     <= '0;
      typ      <= 1'b0;
      tx_byte  <= '0;
      ack_tx   <= 1'b0;
      busy     <= 1'b0;
      txd      <= 1'b1;
    end else begin
      state    <= state_d;
      div_cnt  <= div_cnt_d;
      bit_cnt  <= bit_cnt_d;
      char_cnt <= char_cnt_d;
      word     <= word_d;
      typ      <= typ_d;
      tx_byte  <= tx_byte_d;
      ack_tx   <= ack_d;
      busy     <= busy_d;
      txd      <= txd_d;
    end
  end

  // Outputs are computed for the next state and registered, so txd leads with no input path.
  always_comb begin
    state_d    = state;
    div_cnt_d  = div_cnt;
    bit_cnt_d  = bit_cnt;
    char_cnt_d = char_cnt;
    word_d     = word;
    typ_d      = typ;
    tx_byte_d  = tx_byte;
    ack_d      = 1'b0;
    busy_d     = busy;
    txd_d      = txd;
    n_chars    = typ ? HEX_CHARS : 4'd1;
    char_nxt   = char_cnt + 4'd1;
    case (state)
      IDLE: begin
        if (req_tx) begin
          word_d     = din;
          typ_d      = type_tx;
          char_cnt_d = '0;
          busy_d     = 1'b1;
          div_cnt_d  = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        // Hex digits are taken from the top nibble and the word shifted up.
        if (!typ) tx_byte_d = word[7:0];
`ifdef TX_HEX_SPACE_EN
        else if (char_cnt == 4'd8) tx_byte_d = 8'h20;
`endif
        else begin
          tx_byte_d = hex_ascii(word[31:28]);
          word_d    = {word[27:0], 4'h0};
        end
        div_cnt_d = '0;
        txd_d     = 1'b0;
        state_d   = START;
      end
      START: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_d = '0;
          bit_cnt_d = '0;
          txd_d     = tx_byte[0];
          state_d   = BITS;
        end else begin
          div_cnt_d = div_cnt + 1'b1;
        end
      end
      BITS: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt == 3'd7) begin
            txd_d   = 1'b1;
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt + 3'd1;
            tx_byte_d = {1'b0, tx_byte[7:1]};
            txd_d     = tx_byte[1];
          end
        end else begin
          div_cnt_d = div_cnt + 1'b1;
        end
      end
      STOP: begin
        if (div_cnt == DIV_LAST) begin
          div_cnt_d  = '0;
          char_cnt_d = char_nxt;
          if (char_nxt < n_chars) begin
            state_d = LOAD;
          end else begin
            ack_d   = 1'b1;
            state_d = ACK;
          end
        end else begin
          div_cnt_d = div_cnt + 1'b1;
        end
      end
      ACK: begin
        busy_d    = 1'b0;
        div_cnt_d = '0;
        state_d   = REARM;
      end
      REARM: begin
        if (!req_tx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcp_tx_fmt.sv
// tb/tb_dcp_tx_fmt.sv - directed bench for dcp_tx_fmt at DIV=4 with a mid-bit UART monitor.
module tb_dcp_tx_fmt;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_tx;
  logic        type_tx;
  logic [31:0] din;
  logic        ack_tx;
  logic        busy;
  logic        txd;

`ifdef TX_HEX_SPACE_EN
  localparam int HEX_N = 9;
`else
  localparam int HEX_N = 8;
`endif
  localparam int CHAR_CLKS = 41;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_cnt  = 0;
  int frame_err = 0;
  logic [7:0] rx_q[$];

  logic       m_on = 1'b0;
  int         m_c  = 0;
  logic [7:0] m_b  = '0;

  dcp_tx_fmt #(.CLK_FREQ(4), .BAUD(1)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req_tx  (req_tx),
    .type_tx (type_tx),
    .din     (din),
    .ack_tx  (ack_tx),
    .busy    (busy),
    .txd     (txd)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame starts on the first low sample; bit j is sampled at 6+4j, stop at 38.
  always @(negedge clk) begin
    if (!rstn) begin
      m_on <= 1'b0;
    end else begin
      if (ack_tx) ack_cnt <= ack_cnt + 1;
      if (!m_on) begin
        if (txd == 1'b0) begin
          m_on <= 1'b1;
          m_c  <= 0;
        end
      end else begin
        m_c <= m_c + 1;
        if (m_c + 1 >= 6 && m_c + 1 <= 34 && ((m_c + 1 - 6) % 4) == 0)
          m_b[(m_c + 1 - 6) / 4] <= txd;
        if (m_c + 1 == 38) begin
          if (txd !== 1'b1) frame_err <= frame_err + 1;
          rx_q.push_back(m_b);
          m_on <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_req(input logic t, input logic [31:0] d, output int t_busy);
    @(negedge clk);
    req_tx  = 1'b1;
    type_tx = t;
    din     = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy) break;
    end
    check("accept_busy", 64'(busy), 64'd1);
    t_busy = cyc;
  endtask

  task automatic wait_ack(input int t_busy, output int lat);
    bit found;
    found = 0;
    lat   = 0;
    for (int i = 0; i < 1000; i++) begin
      if (ack_tx) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("ack_seen", 64'(found), 64'd1);
    lat = cyc - t_busy + 1;
  endtask

  task automatic check_bytes(input string tag, input int n, input logic [71:0] exp);
    check({tag, "_nbytes"}, 64'(rx_q.size()), 64'(n));
    for (int i = 0; i < n && i < rx_q.size(); i++)
      check({tag, "_byte"}, 64'(rx_q[i]), 64'(exp[71 - 8*i -: 8]));
  endtask

  task automatic run_req(input string tag, input logic t, input logic [31:0] d, input int n,
                         input logic [71:0] exp, input bit hold);
    int tb, lat, a0;
    rx_q.delete();
    a0 = ack_cnt;
    start_req(t, d, tb);
    wait_ack(tb, lat);
    check({tag, "_lat"}, 64'(lat), 64'(1 + n * CHAR_CLKS));
    if (!hold) req_tx = 1'b0;
    @(negedge clk);
    check({tag, "_ack_pulse"}, 64'(ack_tx), 64'd0);
    check({tag, "_busy_off"}, 64'(busy), 64'd0);
    check({tag, "_ack_cnt"}, 64'(ack_cnt - a0), 64'd1);
    check_bytes(tag, n, exp);
  endtask

  function automatic logic [71:0] hexexp(input logic [63:0] s);
    return {s, 8'h20};
  endfunction

  initial begin
    int tb, lat, a0;
    rstn = 1'b0; req_tx = 1'b0; type_tx = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", 64'(txd), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ack", 64'(ack_tx), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    run_req("raw_R", 1'b0, 32'h0000_0052, 1, {8'h52, 64'd0}, 0);
    run_req("hex_1234ABCD", 1'b1, 32'h1234_ABCD, HEX_N, hexexp(64'h3132_3334_4142_4344), 0);
    run_req("hex_09A0F00F", 1'b1, 32'h09A0_F00F, HEX_N, hexexp(64'h3039_4130_4630_3046), 0);
    run_req("hex_FFFFFFFF", 1'b1, 32'hFFFF_FFFF, HEX_N, hexexp(64'h4646_4646_4646_4646), 0);

    // Held request after ack: no resend until req_tx is seen low.
    run_req("held", 1'b0, 32'h0000_0041, 1, {8'h41, 64'd0}, 1);
    rx_q.delete();
    a0 = ack_cnt;
    repeat (10) begin
      @(negedge clk);
      check("held_busy", 64'(busy), 64'd0);
      check("held_txd", 64'(txd), 64'd1);
    end
    check("held_nbytes", 64'(rx_q.size()), 64'd0);
    check("held_acks", 64'(ack_cnt - a0), 64'd0);
    req_tx = 1'b0;
    @(negedge clk);
    run_req("rearm", 1'b0, 32'h0000_007A, 1, {8'h7A, 64'd0}, 0);

    // Reset during bit 3 of the second char ('2' = 0x32, bit 3 = 0).
    rx_q.delete();
    a0 = ack_cnt;
    start_req(1'b1, 32'h1234_ABCD, tb);
    while (cyc - tb + 1 < 59) @(negedge clk);
    check("pre_rst_txd", 64'(txd), 64'd0);
    rstn = 1'b0;
    #1;
    check("async_txd", 64'(txd), 64'd1);
    check("async_busy", 64'(busy), 64'd0);
    req_tx = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_no_ack", 64'(ack_cnt - a0), 64'd0);
    check_bytes("rst_partial", 1, {8'h31, 64'd0});
    rstn = 1'b1;
    @(negedge clk);
    run_req("post_rst", 1'b1, 32'h1234_ABCD, HEX_N, hexexp(64'h3132_3334_4142_4344), 0);

    // Inputs changed and req dropped mid-word; latched word still completes.
    rx_q.delete();
    a0 = ack_cnt;
    start_req(1'b1, 32'hDEAD_BEEF, tb);
    repeat (60) @(negedge clk);
    din = 32'h0000_0000; type_tx = 1'b0; req_tx = 1'b0;
    wait_ack(tb, lat);
    check("drop_lat", 64'(lat), 64'(1 + HEX_N * CHAR_CLKS));
    @(negedge clk);
    check("drop_acks", 64'(ack_cnt - a0), 64'd1);
    check_bytes("drop", HEX_N, hexexp(64'h4445_4144_4245_4546));

    repeat (5) @(negedge clk);
    check("frame_err", 64'(frame_err), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
